uart_cmd_decoder: RTL and testbench

//  Receive end of the host tuning link. Deserialises 8N1 UART bytes from serial_rx and

---
 rtl/uart_cmd_decoder.sv | 174 +++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// 8N1 UART receiver feeding a 5-byte command-frame parser (SYNC, ADDR, DATA_HI, DATA_LO, CHK)
// that issues one-cycle register-write strobes and flags framing/checksum faults.
module uart_cmd_decoder #(
  parameter int          CLKS_PER_BIT = 87,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        serial_rx,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_err,
  output logic        chk_err
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  MID_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0]  BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam int                TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int                TO_W     = $clog2(TO_LIMIT + 1);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TO_LIMIT);

  typedef enum logic [1:0] {BIT_IDLE, BIT_START, BIT_DATA, BIT_STOP} bit_state_t;
  typedef enum logic [2:0] {WAIT_SYNC, GET_ADDR, GET_HI, GET_LO, GET_CHK} frame_state_t;

  logic             rx_meta_reg;
  logic             rxs_reg;
  bit_state_t       bit_state_reg;
  logic [CNT_W-1:0] clk_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;

  frame_state_t     frame_state_reg;
  logic [7:0]       addr_hold_reg;
  logic [7:0]       hi_hold_reg;
  logic [7:0]       lo_hold_reg;
  logic [7:0]       chk_reg;
  logic [TO_W-1:0]  to_cnt_reg;

  logic stop_sample;
  logic byte_valid;
  logic stop_bad;

  // The frame parser reacts in the same cycle as the stop-bit sample so its strobes
  // land exactly one clock after that sample, just like frame_err.
  assign stop_sample = (bit_state_reg == BIT_STOP) && (clk_cnt_reg == BIT_END);
  assign byte_valid  = stop_sample && rxs_reg;
  assign stop_bad    = stop_sample && !rxs_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rxs_reg     <= 1'b1;
    end else begin
      rx_meta_reg <= serial_rx;
      rxs_reg     <= rx_meta_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_state_reg <= BIT_IDLE;
      clk_cnt_reg   <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      frame_err     <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      case (bit_state_reg)
        BIT_IDLE: begin
          if (!rxs_reg) begin
            bit_state_reg <= BIT_START;
            clk_cnt_reg   <= '0;
          end
        end
        BIT_START: begin
          if (clk_cnt_reg == MID_CNT) begin
            clk_cnt_reg   <= '0;
            bit_idx_reg   <= '0;
            bit_state_reg <= rxs_reg ? BIT_IDLE : BIT_DATA;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end
        BIT_DATA: begin
          if (clk_cnt_reg == BIT_END) begin
            clk_cnt_reg <= '0;
            shift_reg   <= {rxs_reg, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7)
              bit_state_reg <= BIT_STOP;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end
        BIT_STOP: begin
          // Leaving at mid stop bit leaves half a bit of slack before the next start edge.
          if (clk_cnt_reg == BIT_END) begin
            clk_cnt_reg   <= '0;
            bit_state_reg <= BIT_IDLE;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
          end
        end
        default: bit_state_reg <= BIT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_state_reg <= WAIT_SYNC;
      addr_hold_reg   <= '0;
      hi_hold_reg     <= '0;
      lo_hold_reg     <= '0;
      chk_reg         <= '0;
      to_cnt_reg      <= '0;
      wr_en           <= 1'b0;
      wr_addr         <= '0;
      wr_data         <= '0;
      chk_err         <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      chk_err <= 1'b0;
      if (byte_valid) begin
        to_cnt_reg <= '0;
        case (frame_state_reg)
          WAIT_SYNC: if (shift_reg == SYNC_BYTE) frame_state_reg <= GET_ADDR;
          GET_ADDR: begin
            addr_hold_reg   <= shift_reg;
            chk_reg         <= shift_reg;
            frame_state_reg <= GET_HI;
          end
          GET_HI: begin
            hi_hold_reg     <= shift_reg;
            chk_reg         <= chk_reg ^ shift_reg;
            frame_state_reg <= GET_LO;
          end
          GET_LO: begin
            lo_hold_reg     <= shift_reg;
            chk_reg         <= chk_reg ^ shift_reg;
            frame_state_reg <= GET_CHK;
          end
          GET_CHK: begin
            if (shift_reg == chk_reg) begin
              wr_en   <= 1'b1;
              wr_addr <= addr_hold_reg;
              wr_data <= {hi_hold_reg, lo_hold_reg};
            end else begin
              chk_err <= 1'b1;
            end
            frame_state_reg <= WAIT_SYNC;
          end
          default: frame_state_reg <= WAIT_SYNC;
        endcase
      end else if (stop_bad) begin
        frame_state_reg <= WAIT_SYNC;
        to_cnt_reg      <= '0;
      end else if (frame_state_reg != WAIT_SYNC) begin
        // Inter-byte watchdog: abandon a stalled frame without raising a flag.
        if (to_cnt_reg == TO_MAX) begin
          frame_state_reg <= WAIT_SYNC;
        end else begin
          to_cnt_reg <= to_cnt_reg + 1'b1;
        end
      end else begin
        to_cnt_reg <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: a table of whole frames plus hand sequences for
// reset, glitch, bad stop bit and inter-byte timeout.
module tb_uart_cmd_decoder;

  localparam int BIT_CLKS = 87;

  logic        clk = 1'b0;
  logic        reset;
  logic        serial_rx;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_err;
  logic        chk_err;

  int tests_run = 0;
  int tests_failed = 0;

  // Monitor totals, written only by the monitor process.
  int wr_total = 0;
  int chk_total = 0;
  int fe_total = 0;
  int viol_total = 0;
  logic wr_prev = 1'b0, chk_prev = 1'b0, fe_prev = 1'b0;

  uart_cmd_decoder #(
    .CLKS_PER_BIT(BIT_CLKS),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .serial_rx(serial_rx),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_err(frame_err),
    .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) wr_total++;
    if (chk_err) chk_total++;
    if (frame_err) fe_total++;
    if ((wr_en && wr_prev) || (chk_err && chk_prev) || (frame_err && fe_prev)) viol_total++;
    if (wr_en && chk_err) viol_total++;
    wr_prev  = wr_en;
    chk_prev = chk_err;
    fe_prev  = frame_err;
  end

  typedef struct {
    logic [39:0] frame;
    int          exp_wr;
    int          exp_chk;
    logic [7:0]  exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_clks(input int n);
    serial_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    serial_rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      serial_rx = b[k];
      repeat (BIT_CLKS) @(negedge clk);
    end
    serial_rx = stop_val;
    repeat (BIT_CLKS) @(negedge clk);
    serial_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int k = 0; k < 5; k++) send_byte(f[39-8*k -: 8], 1'b1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wr_en"}, int'(wr_en), 0);
    check({tag, "_wr_addr"}, int'(wr_addr), 0);
    check({tag, "_wr_data"}, int'(wr_data), 0);
    check({tag, "_frame_err"}, int'(frame_err), 0);
    check({tag, "_chk_err"}, int'(chk_err), 0);
  endtask

  initial begin
    int w0, c0, f0;

    vecs[0] = '{40'hA5_03_12_34_25, 1, 0, 8'h03, 16'h1234};
    vecs[1] = '{40'hA5_03_12_34_26, 0, 1, 8'h03, 16'h1234};
    vecs[2] = '{40'hA5_07_AB_CD_61, 1, 0, 8'h07, 16'hABCD};
    vecs[3] = '{40'h5A_03_12_34_25, 0, 0, 8'h07, 16'hABCD};
    vecs[4] = '{40'hA5_A5_A5_A5_A5, 1, 0, 8'hA5, 16'hA5A5};
    vecs[5] = '{40'hA5_10_FF_00_EF, 1, 0, 8'h10, 16'hFF00};

    serial_rx = 1'b1;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    idle_clks(20);

    // Reset in the middle of a partial frame and mid-byte: nothing may be written.
    w0 = wr_total;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h12, 1'b1);
    serial_rx = 1'b0;
    repeat (200) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    serial_rx = 1'b1;
    reset = 1'b0;
    idle_clks(3 * BIT_CLKS);
    check_outputs_zero("midreset");
    check("midreset_no_wr", wr_total - w0, 0);

    w0 = wr_total;
    send_frame(40'hA5_03_12_34_25);
    idle_clks(3 * BIT_CLKS);
    check("post_reset_wr", wr_total - w0, 1);
    check("post_reset_addr", int'(wr_addr), 8'h03);
    check("post_reset_data", int'(wr_data), 16'h1234);

    for (int i = 0; i < 6; i++) begin
      w0 = wr_total; c0 = chk_total; f0 = fe_total;
      send_frame(vecs[i].frame);
      idle_clks(3 * BIT_CLKS);
      check($sformatf("v%0d_wr_count", i), wr_total - w0, vecs[i].exp_wr);
      check($sformatf("v%0d_chk_count", i), chk_total - c0, vecs[i].exp_chk);
      check($sformatf("v%0d_fe_count", i), fe_total - f0, 0);
      check($sformatf("v%0d_addr", i), int'(wr_addr), int'(vecs[i].exp_addr));
      check($sformatf("v%0d_data", i), int'(wr_data), int'(vecs[i].exp_data));
      $display("[TB] vector %0d frame %h wr=%0d chk=%0d addr=%h data=%h",
               i, vecs[i].frame, wr_total - w0, chk_total - c0, wr_addr, wr_data);
    end

    // Short low glitch on an idle line must be rejected without a flag.
    w0 = wr_total; f0 = fe_total;
    serial_rx = 1'b0;
    repeat (20) @(negedge clk);
    idle_clks(3 * BIT_CLKS);
    check("glitch_no_fe", fe_total - f0, 0);
    check("glitch_no_wr", wr_total - w0, 0);
    send_frame(40'hA5_03_12_34_25);
    idle_clks(3 * BIT_CLKS);
    check("glitch_then_wr", wr_total - w0, 1);
    check("glitch_then_addr", int'(wr_addr), 8'h03);
    $display("[TB] glitch sequence fe=%0d wr=%0d", fe_total - f0, wr_total - w0);

    // Bad stop bit inside a frame, then a fresh good frame.
    w0 = wr_total; f0 = fe_total; c0 = chk_total;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b0);
    idle_clks(3 * BIT_CLKS);
    check("badstop_fe", fe_total - f0, 1);
    check("badstop_no_wr", wr_total - w0, 0);
    send_frame(40'hA5_07_AB_CD_61);
    idle_clks(3 * BIT_CLKS);
    check("badstop_then_wr", wr_total - w0, 1);
    check("badstop_then_addr", int'(wr_addr), 8'h07);
    check("badstop_then_data", int'(wr_data), 16'hABCD);
    check("badstop_no_chk", chk_total - c0, 0);
    $display("[TB] bad-stop sequence fe=%0d wr=%0d", fe_total - f0, wr_total - w0);

    // Inter-byte gap beyond the timeout abandons the frame.
    w0 = wr_total; c0 = chk_total;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    idle_clks(25 * BIT_CLKS);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h25, 1'b1);
    idle_clks(3 * BIT_CLKS);
    check("timeout_no_wr", wr_total - w0, 0);
    check("timeout_no_chk", chk_total - c0, 0);
    check("timeout_addr_held", int'(wr_addr), 8'h07);
    send_frame(40'hA5_03_12_34_25);
    idle_clks(3 * BIT_CLKS);
    check("timeout_then_wr", wr_total - w0, 1);
    check("timeout_then_addr", int'(wr_addr), 8'h03);
    check("timeout_then_data", int'(wr_data), 16'h1234);
    $display("[TB] timeout sequence wr=%0d chk=%0d", wr_total - w0, chk_total - c0);

    check("pulse_shape_violations", viol_total, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
